// File: rtl/bcd_display_driver.sv
// bcd_display_driver
// Captures an 8-bit value on a strobe, converts it to decimal with an iterative
// double-dabble engine (one bit per cycle) and drives three digit displays plus
// a sign display. A one-deep pending buffer holds a value that arrives while a
// conversion is running; the newest such value wins.
module bcd_display_driver #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DIGITS     = 3,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              signed_mode,
    input  logic              blank_lz,
    output logic              busy,
    output logic              done,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex_sign
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    // Active-low segment patterns, gfedcba order.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [DATA_W-1:0]  shift_reg, shift_next;
    logic [BCD_W-1:0]   bcd_reg, bcd_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               neg_reg, neg_next;
    logic               pend_valid_reg, pend_valid_next;
    logic [DATA_W-1:0]  pend_data_reg, pend_data_next;
    logic               pend_signed_reg, pend_signed_next;
    logic [BCD_W-1:0]   disp_bcd_reg, disp_bcd_next;
    logic               disp_neg_reg, disp_neg_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    // Nibble-wise "add 3 if >= 5" correction applied before every shift.
    logic [BCD_W-1:0]   bcd_adj;

    // Conversion start request and the value it loads.
    logic               ld;
    logic [DATA_W-1:0]  ld_data;
    logic               ld_signed;
    logic               ld_neg;
    logic [DATA_W-1:0]  ld_mag;

    // Per-digit blanking and active-low segment patterns.
    logic [DIGITS-1:0]  blank;
    logic               zero_run;
    logic [6:0]         seg_al [DIGITS];

    // Active-low 7-segment pattern for one BCD digit.
    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Map an active-low pattern onto the configured output polarity.
    function automatic logic [6:0] polarity(input logic [6:0] s);
        return ACTIVE_LOW ? s : ~s;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        (bcd_reg[gi*4 +: 4] + 4'd3) :
                                        bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // State and datapath registers; reset aborts any conversion outright.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            bcd_reg         <= '0;
            cnt_reg         <= '0;
            neg_reg         <= 1'b0;
            pend_valid_reg  <= 1'b0;
            pend_data_reg   <= '0;
            pend_signed_reg <= 1'b0;
            disp_bcd_reg    <= '0;
            disp_neg_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            bcd_reg         <= bcd_next;
            cnt_reg         <= cnt_next;
            neg_reg         <= neg_next;
            pend_valid_reg  <= pend_valid_next;
            pend_data_reg   <= pend_data_next;
            pend_signed_reg <= pend_signed_next;
            disp_bcd_reg    <= disp_bcd_next;
            disp_neg_reg    <= disp_neg_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
        end
    end

    // Next-state logic: capture, shift/adjust, latch on completion, pending buffer.
    always_comb begin
        state_next       = state_reg;
        shift_next       = shift_reg;
        bcd_next         = bcd_reg;
        cnt_next         = cnt_reg;
        neg_next         = neg_reg;
        pend_valid_next  = pend_valid_reg;
        pend_data_next   = pend_data_reg;
        pend_signed_next = pend_signed_reg;
        disp_bcd_next    = disp_bcd_reg;
        disp_neg_next    = disp_neg_reg;
        done_next        = 1'b0;
        ld               = 1'b0;
        ld_data          = data_in;
        ld_signed        = signed_mode;
        ld_neg           = 1'b0;
        ld_mag           = '0;

        case (state_reg)
            IDLE: begin
                // A fresh strobe beats a stale pending value.
                if (sample_valid) begin
                    ld              = 1'b1;
                    pend_valid_next = 1'b0;
                end else if (pend_valid_reg) begin
                    ld              = 1'b1;
                    ld_data         = pend_data_reg;
                    ld_signed       = pend_signed_reg;
                    pend_valid_next = 1'b0;
                end
            end
            CONV: begin
                bcd_next   = {bcd_adj[BCD_W-2:0], shift_reg[DATA_W-1]};
                shift_next = {shift_reg[DATA_W-2:0], 1'b0};
                cnt_next   = cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(DATA_W - 1)) begin
                    state_next = DONE;
                end
                if (sample_valid) begin
                    pend_valid_next  = 1'b1;
                    pend_data_next   = data_in;
                    pend_signed_next = signed_mode;
                end
            end
            DONE: begin
                disp_bcd_next = bcd_reg;
                disp_neg_next = neg_reg;
                done_next     = 1'b1;
                state_next    = IDLE;
                if (pend_valid_reg) begin
                    ld              = 1'b1;
                    ld_data         = pend_data_reg;
                    ld_signed       = pend_signed_reg;
                    pend_valid_next = 1'b0;
                end
                if (sample_valid) begin
                    pend_valid_next  = 1'b1;
                    pend_data_next   = data_in;
                    pend_signed_next = signed_mode;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Negative two's-complement inputs convert as their magnitude.
        ld_neg = ld_signed && ld_data[DATA_W-1];
        ld_mag = ld_neg ? ((~ld_data) + {{(DATA_W-1){1'b0}}, 1'b1}) : ld_data;

        if (ld) begin
            shift_next = ld_mag;
            neg_next   = ld_neg;
            bcd_next   = '0;
            cnt_next   = '0;
            state_next = CONV;
        end

        busy_next = (state_next != IDLE);
    end

    // Leading-zero blanking runs down from the top digit; units never blank.
    always_comb begin
        blank    = '0;
        zero_run = blank_lz;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (disp_bcd_reg[i*4 +: 4] == 4'd0);
            blank[i] = zero_run;
        end
    end

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_seg
            assign seg_al[gi] = blank[gi] ? SEG_BLANK : seg_lut(disp_bcd_reg[gi*4 +: 4]);
        end
    endgenerate

    assign hex0     = polarity(seg_al[0]);
    assign hex1     = polarity(seg_al[1]);
    assign hex2     = polarity(seg_al[2]);
    assign hex_sign = polarity(disp_neg_reg ? SEG_MINUS : SEG_BLANK);
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule
